// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request to imem, result held for decode until taken.
// Latency ack cycle + 1 to instr_valid; decode backpressure holds the instruction, stall only gates new fetches.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic        jump_pend;
  logic [15:0] pc_tgt;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= 16'h0000;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
      jump_pend   <= 1'b0;
      pc_tgt      <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (jump) pc <= jump_addr;
          if (!stall) state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            // A redirect seen during the request turns the returned word into a discard.
            if (jump) begin
              pc        <= jump_addr;
              jump_pend <= 1'b0;
            end else if (jump_pend) begin
              pc        <= pc_tgt;
              jump_pend <= 1'b0;
            end else begin
              instr       <= imem_data;
              instr_pc    <= pc;
              pc          <= pc + 16'd1;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (jump) begin
            jump_pend <= 1'b1;
            pc_tgt    <= jump_addr;
          end
        end
        HOLD: begin
          if (jump) begin
            instr_valid <= 1'b0;
            pc          <= jump_addr;
            state       <= FETCH;
          end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            state       <= stall ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
